// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per clock, unsigned or signed
// (truncating) per operation, with a ready/start/done handshake and a defined divide-by-zero result.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] R,
    output logic             err
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] div_q;
    logic [CW-1:0]    cnt_q;
    logic             negQ_q;
    logic             negR_q;
    logic             zero_q;
    logic             done_q;
    logic             err_q;
    logic [WIDTH-1:0] dOut_q;
    logic [WIDTH-1:0] rOut_q;

    logic [WIDTH-1:0] absA_d;
    logic [WIDTH-1:0] absB_d;
    logic [WIDTH:0]   trial_d;
    logic [WIDTH-1:0] quoFix_d;
    logic [WIDTH-1:0] remFix_d;

    // Magnitudes are only needed at accept, sign fixes only in FIX; the RUN
    // path is just the (WIDTH+1)-bit trial subtract.
    always_comb begin
        absA_d   = (signed_mode && A[WIDTH-1]) ? -A : A;
        absB_d   = (signed_mode && B[WIDTH-1]) ? -B : B;
        trial_d  = {rem_q, quo_q[WIDTH-1]} - {1'b0, div_q};
        quoFix_d = negQ_q ? -quo_q : quo_q;
        remFix_d = negR_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            quo_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            negQ_q  <= 1'b0;
            negR_q  <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dOut_q  <= '0;
            rOut_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        negQ_q <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
                        negR_q <= signed_mode & A[WIDTH-1];
                        rem_q  <= '0;
                        div_q  <= absB_d;
                        cnt_q  <= CW'(WIDTH - 1);
                        // A zero divisor keeps the raw dividend so FIX can return it as R.
                        if (B == '0) begin
                            zero_q  <= 1'b1;
                            quo_q   <= A;
                            state_q <= FIX;
                        end else begin
                            zero_q  <= 1'b0;
                            quo_q   <= absA_d;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!trial_d[WIDTH]) begin
                        rem_q <= trial_d[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                FIX: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                    if (zero_q) begin
                        dOut_q <= '1;
                        rOut_q <= quo_q;
                        err_q  <= 1'b1;
                    end else begin
                        dOut_q <= quoFix_d;
                        rOut_q <= remFix_d;
                        err_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign D     = dOut_q;
    assign R     = rOut_q;
    assign err   = err_q;

endmodule
